// File: rtl/cond_pkg.sv
// Shared definitions for the NZCV condition unit: flag bit positions, condition
// encodings and the single-lane condition evaluator.
package cond_pkg;

  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Encoding 4'hF has no dedicated meaning here and falls into the always-true default.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic r;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_eval_lane.sv
// Combinational condition check for one issue lane against the effective flags.
module cond_eval_lane
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  assign pass = cond_eval(cond, flags);

endmodule

// File: rtl/cond_flag_unit.sv
// NZCV flag holder with outstanding flag-op tracking and per-lane condition
// evaluation; lanes whose condition depends on unresolved flags are held off.
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int STATUS_W  = 32,
  parameter int FLAG_LSB  = 28,
  parameter int NUM_LANES = 2,
  parameter int MAX_PEND  = 3,
  parameter int BYPASS    = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flag_wr_en,
  input  logic [3:0]                      flag_wr_mask,
  input  logic [3:0]                      flag_wr_data,
  input  logic                            flag_wr_retire,
  input  logic                            pend_inc,
  input  logic [NUM_LANES-1:0]            lane_valid,
  input  logic [4*NUM_LANES-1:0]          lane_cond,
  output logic [NUM_LANES-1:0]            lane_ready,
  output logic [NUM_LANES-1:0]            lane_pass,
  output logic [NUM_LANES-1:0]            lane_pass_vld,
  output logic [STATUS_W-1:0]             status_reg_out,
  output logic [$clog2(MAX_PEND+1)-1:0]   pend_cnt,
  output logic                            pend_full,
  output logic                            err_ovf
);

  localparam int PCW = $clog2(MAX_PEND + 1);

  logic [3:0]           flags_q;
  logic [3:0]           wr_mask;
  logic [3:0]           flags_merged;
  logic [3:0]           flags_eff;
  logic                 ret;
  logic [PCW-1:0]       pend_eff;
  logic [PCW-1:0]       pend_nxt;
  logic                 ovf_set;
  logic [NUM_LANES-1:0] lane_res;

  assign wr_mask      = flag_wr_mask & {4{flag_wr_en}};
  assign flags_merged = (flags_q & ~wr_mask) | (flag_wr_data & wr_mask);
  assign pend_full    = (pend_cnt == PCW'(MAX_PEND));
  assign ret          = flag_wr_en & flag_wr_retire & (pend_cnt != '0);

  // With bypass, a retire landing this cycle already counts as resolved for the lanes.
  assign flags_eff = (BYPASS != 0) ? flags_merged : flags_q;
  assign pend_eff  = (BYPASS != 0) ? (pend_cnt - PCW'(ret)) : pend_cnt;

  always_comb begin
    pend_nxt = pend_cnt;
    ovf_set  = 1'b0;
    if (pend_inc && !ret) begin
      if (pend_full) ovf_set = 1'b1;
      else           pend_nxt = pend_cnt + PCW'(1);
    end else if (ret && !pend_inc) begin
      pend_nxt = pend_cnt - PCW'(1);
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [3:0] cond_i;
    assign cond_i = lane_cond[4*i +: 4];
    assign lane_ready[i] = lane_valid[i] & ((pend_eff == '0) | (cond_i[3:1] == 3'b111));
    cond_eval_lane u_eval (
      .cond  (cond_i),
      .flags (flags_eff),
      .pass  (lane_res[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q       <= '0;
      pend_cnt      <= '0;
      err_ovf       <= 1'b0;
      lane_pass     <= '0;
      lane_pass_vld <= '0;
    end else begin
      flags_q       <= flags_merged;
      pend_cnt      <= pend_nxt;
      err_ovf       <= err_ovf | ovf_set;
      lane_pass     <= lane_ready & lane_res;
      lane_pass_vld <= lane_ready;
    end
  end

  always_comb begin
    status_reg_out = '0;
    status_reg_out[FLAG_LSB +: 4] = flags_q;
  end

endmodule

// File: tb/tb_cond_flag_unit.sv
// Bench for cond_flag_unit: two instances (bypass on/off) driven in lockstep and
// compared against a behavioural flag/pending model, with directed and random steps.
module tb_cond_flag_unit;

  localparam int MAXP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flag_wr_en = 1'b0;
  logic [3:0] flag_wr_mask = '0;
  logic [3:0] flag_wr_data = '0;
  logic       flag_wr_retire = 1'b0;
  logic       pend_inc = 1'b0;
  logic [1:0] lane_valid = '0;
  logic [7:0] lane_cond = '0;

  logic [1:0]  rdy1, pass1, vld1, rdy0, pass0, vld0;
  logic [31:0] st1, st0;
  logic [1:0]  cnt1, cnt0;
  logic        full1, full0, ovf1, ovf0;

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  int         m_pend = 0;
  logic [3:0] m_flags = '0;
  logic       m_ovf = 1'b0;
  logic [1:0] e_pass1 = '0, e_vld1 = '0, e_pass0 = '0, e_vld0 = '0;

  always #5 clk = ~clk;

  cond_flag_unit #(.STATUS_W(32), .FLAG_LSB(28), .NUM_LANES(2), .MAX_PEND(MAXP), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .flag_wr_en(flag_wr_en), .flag_wr_mask(flag_wr_mask),
    .flag_wr_data(flag_wr_data), .flag_wr_retire(flag_wr_retire), .pend_inc(pend_inc),
    .lane_valid(lane_valid), .lane_cond(lane_cond), .lane_ready(rdy1), .lane_pass(pass1),
    .lane_pass_vld(vld1), .status_reg_out(st1), .pend_cnt(cnt1), .pend_full(full1), .err_ovf(ovf1)
  );

  cond_flag_unit #(.STATUS_W(32), .FLAG_LSB(28), .NUM_LANES(2), .MAX_PEND(MAXP), .BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flag_wr_en(flag_wr_en), .flag_wr_mask(flag_wr_mask),
    .flag_wr_data(flag_wr_data), .flag_wr_retire(flag_wr_retire), .pend_inc(pend_inc),
    .lane_valid(lane_valid), .lane_cond(lane_cond), .lane_ready(rdy0), .lane_pass(pass0),
    .lane_pass_vld(vld0), .status_reg_out(st0), .pend_cnt(cnt0), .pend_full(full0), .err_ovf(ovf0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pairs (base condition, inverted) over encodings 0..13; 14 and 15 always hold.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c >= 4'd14) return 1'b1;
    case (c >> 1)
      3'd0:    base = z;
      3'd1:    base = cy;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cy && !z;
      3'd5:    base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic idle();
    flag_wr_en = 0; flag_wr_mask = '0; flag_wr_data = '0; flag_wr_retire = 0;
    pend_inc = 0; lane_valid = '0; lane_cond = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_pass1"}, {30'd0, pass1}, {30'd0, e_pass1});
    chk({tag, "_vld1"},  {30'd0, vld1},  {30'd0, e_vld1});
    chk({tag, "_pass0"}, {30'd0, pass0}, {30'd0, e_pass0});
    chk({tag, "_vld0"},  {30'd0, vld0},  {30'd0, e_vld0});
    chk({tag, "_cnt1"},  {30'd0, cnt1},  32'(m_pend));
    chk({tag, "_cnt0"},  {30'd0, cnt0},  32'(m_pend));
    chk({tag, "_full"},  {31'd0, full1}, 32'(m_pend == MAXP));
    chk({tag, "_ovf"},   {31'd0, ovf1},  {31'd0, m_ovf});
    chk({tag, "_st1"},   st1, {m_flags, 28'd0});
    chk({tag, "_st0"},   st0, {m_flags, 28'd0});
  endtask

  // One clock: check ready before the edge, advance the model, check registers after.
  task automatic step(input string tag);
    logic       ret;
    logic [3:0] wm, merged;
    int         pe1, pe0;
    logic [1:0] r1, r0;
    #1;
    ret    = flag_wr_en && flag_wr_retire && (m_pend != 0);
    wm     = flag_wr_en ? flag_wr_mask : 4'h0;
    merged = (m_flags & ~wm) | (flag_wr_data & wm);
    pe1 = m_pend - int'(ret);
    pe0 = m_pend;
    for (int i = 0; i < 2; i++) begin
      logic [3:0] c;
      c = lane_cond[4*i +: 4];
      r1[i] = lane_valid[i] && (pe1 == 0 || c >= 4'd14);
      r0[i] = lane_valid[i] && (pe0 == 0 || c >= 4'd14);
      e_pass1[i] = r1[i] && ref_cond(c, merged);
      e_pass0[i] = r0[i] && ref_cond(c, m_flags);
    end
    e_vld1 = r1;
    e_vld0 = r0;
    chk({tag, "_rdy1"}, {30'd0, rdy1}, {30'd0, r1});
    chk({tag, "_rdy0"}, {30'd0, rdy0}, {30'd0, r0});
    if (pend_inc && !ret) begin
      if (m_pend == MAXP) m_ovf = 1'b1;
      else m_pend++;
    end else if (ret && !pend_inc) begin
      m_pend--;
    end
    m_flags = merged;
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  task automatic write_flags(input logic [3:0] mask, input logic [3:0] data);
    idle();
    flag_wr_en = 1; flag_wr_mask = mask; flag_wr_data = data;
    step("wr");
    idle();
  endtask

  initial begin
    // reset state
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check_regs("rst");
    rst_n = 1;

    // write Z=1, then EQ / NE
    write_flags(4'hF, 4'b0100);
    lane_valid = 2'b11; lane_cond = {4'h1, 4'h0};
    step("t2");
    chk("t2_pass_const", {30'd0, pass1}, 32'h1);
    chk("t2_vld_const",  {30'd0, vld1},  32'h3);
    idle();

    // same-cycle write Z=1 seen only with bypass
    write_flags(4'hF, 4'h0);
    flag_wr_en = 1; flag_wr_mask = 4'hF; flag_wr_data = 4'b0100;
    lane_valid = 2'b01; lane_cond = {4'h0, 4'h0};
    step("t3");
    chk("t3_byp1", {31'd0, pass1[0]}, 32'h1);
    chk("t3_byp0", {31'd0, pass0[0]}, 32'h0);
    idle();

    // one pending op blocks GE but not AL until retired
    pend_inc = 1;
    step("t4_inc");
    idle();
    lane_valid = 2'b11; lane_cond = {4'hE, 4'hA};
    step("t4_hold_a");
    step("t4_hold_b");
    chk("t4_hold_rdy", {30'd0, rdy1}, 32'h2);
    flag_wr_en = 1; flag_wr_retire = 1; flag_wr_mask = 4'h0;
    #1;
    chk("t4_ret_rdy1", {30'd0, rdy1}, 32'h3);
    chk("t4_ret_rdy0", {30'd0, rdy0}, 32'h2);
    step("t4_ret");
    idle();

    // overflow: four increments against depth three, then inc+retire
    for (int k = 0; k < 4; k++) begin
      pend_inc = 1;
      step("t5_inc");
    end
    chk("t5_cnt", {30'd0, cnt1}, 32'd3);
    chk("t5_ovf", {31'd0, ovf1}, 32'd1);
    pend_inc = 1; flag_wr_en = 1; flag_wr_retire = 1;
    step("t5_incret");
    chk("t5_cnt_hold", {30'd0, cnt1}, 32'd3);
    chk("t5_ovf_sticky", {31'd0, ovf1}, 32'd1);
    idle();
    for (int k = 0; k < 4; k++) begin
      flag_wr_en = 1; flag_wr_retire = 1;
      step("t5_drain");
    end
    idle();

    // async reset mid-operation with pend=2 and flags=F
    write_flags(4'hF, 4'hF);
    pend_inc = 1; step("t1_inc");
    pend_inc = 1; step("t1_inc");
    idle();
    chk("t1_pre_cnt", {30'd0, cnt1}, 32'd2);
    #2 rst_n = 0;
    #1;
    m_pend = 0; m_flags = '0; m_ovf = 1'b0;
    e_pass1 = '0; e_vld1 = '0; e_pass0 = '0; e_vld0 = '0;
    check_regs("t1_rst");
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // exhaustive conditions x flags on both lanes
    for (int f = 0; f < 16; f++) begin
      write_flags(4'hF, 4'(f));
      for (int c = 0; c < 16; c++) begin
        lane_valid = 2'b11;
        lane_cond  = {4'(15 - c), 4'(c)};
        step("t6_sweep");
      end
      idle();
    end
    write_flags(4'hF, 4'b0110);
    lane_valid = 2'b01; lane_cond = {4'h0, 4'h9};
    step("t6_ls");
    chk("t6_ls_const", {31'd0, pass1[0]}, 32'h1);
    write_flags(4'hF, 4'b1000);
    lane_valid = 2'b01; lane_cond = {4'h0, 4'hD};
    step("t6_le");
    chk("t6_le_const", {31'd0, pass1[0]}, 32'h1);
    write_flags(4'b0010, 4'b0111);
    chk("t6_mask_c", st1, 32'hA000_0000);
    idle();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      flag_wr_en     = 1'($urandom);
      flag_wr_mask   = 4'($urandom);
      flag_wr_data   = 4'($urandom);
      flag_wr_retire = 1'($urandom);
      pend_inc       = ($urandom_range(0, 3) == 0);
      lane_valid     = 2'($urandom);
      lane_cond      = 8'($urandom);
      step("rnd");
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
